// File: rtl/cat_draw_ctl.sv
// cat_draw_ctl: overlays the 64x64 cat ROM sprite on the VGA pixel stream.
// The ROM has one clock of latency, so every path through this block is three clocks long.
module cat_draw_ctl #(
  parameter bit          TRANS_EN  = 1'b1,
  parameter logic [11:0] TRANS_KEY = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mirror,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  logic [11:0] xpos_l, ypos_l, rgb1, rgb2;
  logic        mirror_l, vsync_prev, in_win, in_win1, in_win2, show_rom;
  logic [12:0] sub_x, sub_y;
  logic [5:0]  ax;
  logic [25:0] tim0, tim1, tim2, tim3;
  // Bit 12 of each difference is the borrow, so sprites near 4095 never wrap onto column 0.
  assign sub_x    = {2'b00, hcount_in} - {1'b0, xpos_l};
  assign sub_y    = {2'b00, vcount_in} - {1'b0, ypos_l};
  assign in_win   = ~sub_x[12] & ~sub_y[12] & ~|sub_x[11:6] & ~|sub_y[11:6] & ~hblnk_in & ~vblnk_in;
  assign ax       = mirror_l ? ~sub_x[5:0] : sub_x[5:0];
  assign tim0     = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
  assign show_rom = in_win2 & ~(TRANS_EN & (rom_rgb == TRANS_KEY));
  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} = tim3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_l     <= '0;
      ypos_l     <= '0;
      mirror_l   <= 1'b0;
      vsync_prev <= 1'b0;
      rom_addr   <= '0;
      in_win1    <= 1'b0;
      in_win2    <= 1'b0;
      rgb1       <= '0;
      rgb2       <= '0;
      tim1       <= '0;
      tim2       <= '0;
      tim3       <= '0;
      rgb_out    <= '0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) begin
        xpos_l   <= xpos;
        ypos_l   <= ypos;
        mirror_l <= mirror;
      end
      rom_addr <= in_win ? {sub_y[5:0], ax} : 12'h000;
      in_win1  <= in_win;
      rgb1     <= rgb_in;
      tim1     <= tim0;
      in_win2  <= in_win1;
      rgb2     <= rgb1;
      tim2     <= tim1;
      tim3     <= tim2;
      rgb_out  <= (tim2[1] | tim2[0]) ? 12'h000 : show_rom ? rom_rgb : rgb2;
    end
  end
endmodule

// File: tb/tb_cat_draw_ctl.sv
// tb_cat_draw_ctl: table vectors, hand-written corner sequences and random traffic
// against a pixel-level model of the sprite overlay.
module tb_cat_draw_ctl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0, mirror = 1'b0;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0, rom_addr, rom_rgb = '0, rgb_out;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rom_mem [4096];

  cat_draw_ctl dut (
    .clk(clk), .rst_n(rst_n), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .mirror(mirror), .rom_addr(rom_addr),
    .rom_rgb(rom_rgb), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out),
    .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_rgb <= rom_mem[rom_addr];

  typedef struct {
    logic [11:0] addr;
    logic [37:0] outv;
  } exp_t;
  typedef struct {
    logic [11:0] xp, yp;
    bit          m;
    logic [10:0] h, v;
    bit          hb, vb;
    logic [11:0] rgb, addr, out;
  } vec_t;

  exp_t hist[$];
  vec_t tbl[12];
  int   n_chk = 0, n_fail = 0;
  int   xl, yl;
  bit   ml, vsp;

  wire [37:0] outs = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    exp_t z;
    z.addr = '0;
    z.outv = '0;
    xl = 0; yl = 0; ml = 0; vsp = 0;
    hist.delete();
    repeat (3) hist.push_back(z);
  endtask

  // Model: the sprite occupies [xl, xl+64) x [yl, yl+64) in plain integer coordinates.
  task automatic tick();
    exp_t e;
    int dx, dy;
    bit hit;
    logic [11:0] a, r;
    dx  = int'(hcount_in) - xl;
    dy  = int'(vcount_in) - yl;
    hit = dx >= 0 && dx < 64 && dy >= 0 && dy < 64 && !hblnk_in && !vblnk_in;
    a   = hit ? 12'(dy * 64 + (ml ? 63 - dx : dx)) : 12'h000;
    r   = rom_mem[a];
    e.addr = a;
    e.outv = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
              (hblnk_in || vblnk_in) ? 12'h000 : (hit && r != 12'h000) ? r : rgb_in};
    hist.push_back(e);
    if (vsync_in && !vsp) begin
      xl = int'(xpos); yl = int'(ypos); ml = mirror;
    end
    vsp = vsync_in;
    @(posedge clk);
    @(negedge clk);
    chk("model_rom_addr", 64'(rom_addr), 64'(hist[hist.size()-1].addr));
    chk("model_outputs", 64'(outs), 64'(hist[hist.size()-3].outv));
    while (hist.size() > 3) void'(hist.pop_front());
  endtask

  task automatic pixel(input int h, input int v, input logic [11:0] rgb);
    hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = rgb;
    hblnk_in = 1'b0; vblnk_in = 1'b0;
  endtask

  task automatic latch_frame(input logic [11:0] x, input logic [11:0] y, input bit m);
    xpos = x; ypos = y; mirror = m;
    pixel(2047, 2047, 12'h000);
    vsync_in = 1'b0; tick();
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0; tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
    rom_mem[12'h000] = 12'hABC;
    rom_mem[12'hFFF] = 12'h3C3;
    rom_mem[12'h001] = 12'h000;
    rom_mem[12'h03F] = 12'h0F0;
    tbl[0]  = '{12'd100,  12'd50, 1'b0, 11'd100, 11'd50,  1'b0, 1'b0, 12'h123, 12'h000, 12'hABC};
    tbl[1]  = '{12'd100,  12'd50, 1'b0, 11'd163, 11'd113, 1'b0, 1'b0, 12'h123, 12'hFFF, 12'h3C3};
    tbl[2]  = '{12'd100,  12'd50, 1'b0, 11'd164, 11'd50,  1'b0, 1'b0, 12'h456, 12'h000, 12'h456};
    tbl[3]  = '{12'd100,  12'd50, 1'b0, 11'd99,  11'd50,  1'b0, 1'b0, 12'h789, 12'h000, 12'h789};
    tbl[4]  = '{12'd100,  12'd50, 1'b0, 11'd101, 11'd50,  1'b0, 1'b0, 12'h5A5, 12'h001, 12'h5A5};
    tbl[5]  = '{12'd100,  12'd50, 1'b0, 11'd100, 11'd49,  1'b0, 1'b0, 12'h111, 12'h000, 12'h111};
    tbl[6]  = '{12'd100,  12'd50, 1'b0, 11'd100, 11'd114, 1'b0, 1'b0, 12'h999, 12'h000, 12'h999};
    tbl[7]  = '{12'd100,  12'd50, 1'b1, 11'd100, 11'd50,  1'b0, 1'b0, 12'h222, 12'h03F, 12'h0F0};
    tbl[8]  = '{12'd100,  12'd50, 1'b1, 11'd163, 11'd50,  1'b0, 1'b0, 12'h222, 12'h000, 12'hABC};
    tbl[9]  = '{12'd4070, 12'd0,  1'b0, 11'd5,   11'd0,   1'b0, 1'b0, 12'h333, 12'h000, 12'h333};
    tbl[10] = '{12'd100,  12'd50, 1'b0, 11'd110, 11'd60,  1'b1, 1'b0, 12'h777, 12'h000, 12'h000};
    tbl[11] = '{12'd100,  12'd50, 1'b0, 11'd110, 11'd60,  1'b0, 1'b1, 12'h777, 12'h000, 12'h000};

    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(outs), 64'h0);
    chk("reset_rom_addr", 64'(rom_addr), 64'h0);
    reset_model();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      latch_frame(tbl[i].xp, tbl[i].yp, tbl[i].m);
      pixel(tbl[i].h, tbl[i].v, tbl[i].rgb);
      hblnk_in = tbl[i].hb; vblnk_in = tbl[i].vb;
      tick();
      chk($sformatf("tbl%0d_rom_addr", i), 64'(rom_addr), 64'(tbl[i].addr));
      pixel(2047, 2047, 12'h000);
      tick();
      tick();
      chk($sformatf("tbl%0d_rgb_out", i), 64'(rgb_out), 64'(tbl[i].out));
    end

    // Position changes between vsync rises must not move the sprite.
    latch_frame(12'd100, 12'd50, 1'b0);
    xpos = 12'd200;
    pixel(100, 60, 12'h0AA); tick();
    chk("hold_old_pos", 64'(rom_addr), 64'h280);
    vsync_in = 1'b1; pixel(2047, 2047, 12'h000); tick();
    vsync_in = 1'b0;
    pixel(200, 60, 12'h0AA); tick();
    chk("new_pos_hit", 64'(rom_addr), 64'h280);
    pixel(100, 60, 12'h0AA); tick();
    chk("old_pos_miss", 64'(rom_addr), 64'h000);

    // Asynchronous reset in the middle of a line while the sprite is being drawn.
    for (int h = 200; h < 210; h++) begin
      pixel(h, 70, 12'h5A5); tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'(outs), 64'h0);
    chk("async_reset_rom_addr", 64'(rom_addr), 64'h0);
    repeat (2) @(negedge clk);
    reset_model();
    rst_n = 1'b1;
    xpos = 12'd300; ypos = 12'd300;
    pixel(10, 5, 12'h123); tick();
    chk("post_reset_origin", 64'(rom_addr), 64'h14A);
    pixel(11, 5, 12'h123); tick();
    chk("post_reset_flush", 64'(outs), 64'h0);
    vsync_in = 1'b1; tick();
    vsync_in = 1'b0; pixel(300, 300, 12'h123); tick();
    chk("post_reset_latch", 64'(rom_addr), 64'h000);

    // Miniature raster: counts and syncs ride through unchanged.
    latch_frame(12'd20, 12'd3, 1'b0);
    for (int v = 0; v < 25; v++)
      for (int h = 0; h < 100; h++) begin
        pixel(h, v, 12'($urandom));
        hsync_in = h >= 80 && h < 90;
        hblnk_in = h >= 70;
        vblnk_in = v >= 20;
        vsync_in = v == 22;
        tick();
      end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) vsync_in = ~vsync_in;
      if ($urandom_range(0, 60) == 0) begin
        xpos   = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(3990, 4095)) : 12'($urandom_range(0, 300));
        ypos   = 12'($urandom_range(0, 150));
        mirror = 1'($urandom);
      end
      pixel($urandom_range(0, 400), $urandom_range(0, 200), 12'($urandom));
      hsync_in = 1'($urandom);
      hblnk_in = $urandom_range(0, 7) == 0;
      vblnk_in = $urandom_range(0, 7) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
